branch_comparator: RTL and testbench

- Branch comparator for the single-cycle RV32I core.
- Compares the two register-file read operands and reports equality and less-than, either signed or unsigned.
- The combinational result feeds the branch-decision logic in the same cycle (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- A registered copy of the flags is also provided for trace/debug and pipelined reuse.

---
 rtl/branch_comparator_if.sv | 33 +++
 rtl/branch_comparator.sv | 80 ++++++++
 tb/tb_branch_comparator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/branch_comparator_if.sv
// Operand and flag bundle between the register-file read stage and the
// branch comparator; the comparator sits on the slave side.
interface branch_comparator_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] i_rs1_data;
    logic [DATA_WIDTH-1:0] i_rs2_data;
    logic                  i_br_un;
    logic                  o_br_less;
    logic                  o_br_equal;
    logic                  o_br_less_q;
    logic                  o_br_equal_q;

    modport master (
        output i_rs1_data,
        output i_rs2_data,
        output i_br_un,
        input  o_br_less,
        input  o_br_equal,
        input  o_br_less_q,
        input  o_br_equal_q
    );

    modport slave (
        input  i_rs1_data,
        input  i_rs2_data,
        input  i_br_un,
        output o_br_less,
        output o_br_equal,
        output o_br_less_q,
        output o_br_equal_q
    );
endinterface

// File: rtl/branch_comparator.sv
// RV32I branch comparator: nibble-slice magnitude tree with top-level
// sign fix-up; i_br_un=1 selects signed, 0 selects unsigned.
module branch_comparator #(
    parameter int DATA_WIDTH = 32
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    branch_comparator_if.slave   bus
);
    localparam int NS  = DATA_WIDTH / 4;
    localparam int LVL = (NS > 1) ? $clog2(NS) : 0;
    localparam int NP  = 1 << LVL;
    localparam int MSB = DATA_WIDTH - 1;

    logic [NS-1:0] slice_eq;
    logic [NS-1:0] slice_lt;
    logic [NP-1:0] tree_eq;
    logic [NP-1:0] tree_lt;
    logic          ult;
    logic          word_eq;
    logic          msb_diff;
    logic          less;

    // Per-nibble equality and unsigned less-than.
    always_comb begin
        slice_eq = '0;
        slice_lt = '0;
        for (int i = 0; i < NS; i++) begin
            slice_eq[i] = bus.i_rs1_data[4*i +: 4]
                       == bus.i_rs2_data[4*i +: 4];
            slice_lt[i] = bus.i_rs1_data[4*i +: 4]
                        < bus.i_rs2_data[4*i +: 4];
        end
    end

    // Pairwise reduction, high slice dominates; pad slices are neutral.
    always_comb begin
        tree_eq = '1;
        tree_lt = '0;
        for (int i = 0; i < NS; i++) begin
            tree_eq[i] = slice_eq[i];
            tree_lt[i] = slice_lt[i];
        end
        for (int l = 0; l < LVL; l++) begin
            for (int j = 0; j < NP / 2; j++) begin
                if (j < (NP >> (l + 1))) begin
                    tree_lt[j] = tree_lt[2*j+1]
                               | (tree_eq[2*j+1] & tree_lt[2*j]);
                    tree_eq[j] = tree_eq[2*j+1] & tree_eq[2*j];
                end
            end
        end
    end

    assign ult      = tree_lt[0];
    assign word_eq  = tree_eq[0];
    assign msb_diff = bus.i_rs1_data[MSB] ^ bus.i_rs2_data[MSB];

    // Signed: differing MSBs decide by A's sign; otherwise magnitude order.
    always_comb begin
        less = ult;
        if (bus.i_br_un && msb_diff) begin
            less = bus.i_rs1_data[MSB];
        end
    end

    assign bus.o_br_less  = less;
    assign bus.o_br_equal = word_eq;

    // Registered copy of the flags, cleared by synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_br_less_q  <= 1'b0;
            bus.o_br_equal_q <= 1'b0;
        end else begin
            bus.o_br_less_q  <= less;
            bus.o_br_equal_q <= word_eq;
        end
    end
endmodule

// File: tb/tb_branch_comparator.sv
// Directed and random checks of the branch comparator, combinational
// flags immediately and registered flags one edge later.
module tb_branch_comparator;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    branch_comparator_if #(.DATA_WIDTH(32)) bus ();

    branch_comparator #(.DATA_WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic got,
                         input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic un);
        @(negedge clk);
        bus.i_rs1_data = a;
        bus.i_rs2_data = b;
        bus.i_br_un    = un;
        #1;
    endtask

    task automatic run_vec(input string tag,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic un,
                           input logic el,
                           input logic ee);
        drive(a, b, un);
        check({tag, " less"}, bus.o_br_less, el);
        check({tag, " equal"}, bus.o_br_equal, ee);
        @(posedge clk);
        #1;
        check({tag, " less_q"}, bus.o_br_less_q, el);
        check({tag, " equal_q"}, bus.o_br_equal_q, ee);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        un;
        logic        el;
        logic        ee;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.i_rs1_data = 32'd5;
        bus.i_rs2_data = 32'd5;
        bus.i_br_un    = 1'b1;

        @(posedge clk);
        #1;
        check("rst0 less_q", bus.o_br_less_q, 1'b0);
        check("rst0 equal_q", bus.o_br_equal_q, 1'b0);
        check("rst0 equal", bus.o_br_equal, 1'b1);
        drive(32'd1, 32'd2, 1'b1);
        check("rst1 less", bus.o_br_less, 1'b1);
        @(posedge clk);
        #1;
        check("rst1 less_q", bus.o_br_less_q, 1'b0);
        check("rst1 equal_q", bus.o_br_equal_q, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel less_q", bus.o_br_less_q, 1'b1);
        check("rel equal_q", bus.o_br_equal_q, 1'b0);

        run_vec("v01", 32'h00000005, 32'h00000005, 1'b1, 1'b0, 1'b1);
        run_vec("v02", 32'h00000005, 32'h00000005, 1'b0, 1'b0, 1'b1);
        run_vec("v03", 32'h00000001, 32'h00000002, 1'b1, 1'b1, 1'b0);
        run_vec("v04", 32'h00000001, 32'h00000002, 1'b0, 1'b1, 1'b0);
        run_vec("v05", 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        run_vec("v06", 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        run_vec("v07", 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        run_vec("v08", 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        run_vec("v09", 32'h80000000, 32'h80000001, 1'b0, 1'b1, 1'b0);
        run_vec("v10", 32'h80000001, 32'h80000000, 1'b0, 1'b0, 1'b0);
        run_vec("v11", 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0);
        run_vec("v12", 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_vec("v13", 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run_vec("v14", 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        run_vec("v15", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1'b0);
        run_vec("v16", 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0);
        run_vec("v17", 32'h80000000, 32'h80000001, 1'b1, 1'b1, 1'b0);
        run_vec("v18", 32'h80000001, 32'h80000000, 1'b1, 1'b0, 1'b0);
        run_vec("v19", 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        run_vec("v20", 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0);
        run_vec("v21", 32'h12340678, 32'h12345678, 1'b0, 1'b1, 1'b0);
        run_vec("v22", 32'h12345679, 32'h12345678, 1'b1, 1'b0, 1'b0);
        run_vec("v23", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);

        drive(32'd5, 32'd5, 1'b0);
        @(posedge clk);
        #1;
        check("pre equal_q", bus.o_br_equal_q, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid less_q", bus.o_br_less_q, 1'b0);
        check("mid equal_q", bus.o_br_equal_q, 1'b0);
        drive(32'd3, 32'd9, 1'b0);
        check("mid less", bus.o_br_less, 1'b1);
        check("mid equal", bus.o_br_equal, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post less_q", bus.o_br_less_q, 1'b1);

        for (int i = 0; i < 64; i++) begin
            a  = $urandom;
            b  = $urandom;
            un = 1'($urandom_range(0, 1));
            case (i % 4)
                0: b = a;
                1: b = a ^ (32'h1 << $urandom_range(0, 31));
                default: ;
            endcase
            ee = (a == b);
            if (un) el = ($signed(a) < $signed(b));
            else    el = (a < b);
            run_vec($sformatf("rnd%0d", i), a, b, un, el, ee);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
